// File: rtl/fsm_registrador_palpite.sv
// Collects an N_POS-digit Mastermind guess, one digit per confirm press, with undo,
// colour-range validation and a one-cycle "guess complete" pulse.
module fsm_registrador_palpite #(
  parameter int unsigned N_POS   = 4,
  parameter int unsigned W_DIG   = 3,
  parameter int unsigned N_CORES = 6
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          botao,
  input  logic                          voltar,
  input  logic                          limpar,
  input  logic [W_DIG-1:0]              valor,
  output logic [$clog2(N_POS+1)-1:0]    estado,
  output logic [N_POS*W_DIG-1:0]        palpite,
  output logic                          pronto,
  output logic                          erro
);

  localparam int unsigned SW = $clog2(N_POS + 1);
  localparam int unsigned PW = N_POS * W_DIG;
  localparam logic [SW-1:0] CHEIO  = SW'(N_POS);
  localparam logic [SW-1:0] ULTIMA = SW'(N_POS - 1);

  logic          botao_q, voltar_q;
  logic          press_b, press_v, cheio, valido;
  logic [SW-1:0] estado_nxt;
  logic [PW-1:0] palpite_nxt;
  logic          pronto_nxt, erro_nxt;

  assign press_b = botao  & ~botao_q;
  assign press_v = voltar & ~voltar_q;
  assign cheio   = (estado == CHEIO);
  assign valido  = (32'(valor) < N_CORES);

  // State and output registers; edge-detect history loads 1 so a held button is not a press
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      estado   <= '0;
      palpite  <= '0;
      pronto   <= 1'b0;
      erro     <= 1'b0;
      botao_q  <= 1'b1;
      voltar_q <= 1'b1;
    end else begin
      estado   <= estado_nxt;
      palpite  <= palpite_nxt;
      pronto   <= pronto_nxt;
      erro     <= erro_nxt;
      botao_q  <= botao;
      voltar_q <= voltar;
    end
  end

  // Next position
  always_comb begin
    estado_nxt = estado;
    if (limpar) begin
      estado_nxt = '0;
    end else if (press_b && press_v) begin
      estado_nxt = estado;
    end else if (press_b) begin
      if (cheio) begin
        estado_nxt = '0;
      end else if (valido) begin
        estado_nxt = estado + SW'(1);
      end
    end else if (press_v && (estado != '0)) begin
      estado_nxt = estado - SW'(1);
    end
  end

  // Stored digits and pulses
  always_comb begin
    palpite_nxt = palpite;
    pronto_nxt  = 1'b0;
    erro_nxt    = 1'b0;
    if (limpar) begin
      palpite_nxt = '0;
    end else if (press_b && press_v) begin
      palpite_nxt = palpite;
    end else if (press_b) begin
      if (cheio) begin
        palpite_nxt = '0;
      end else if (valido) begin
        for (int i = 0; i < int'(N_POS); i++) begin
          if (SW'(i) == estado) palpite_nxt[i*W_DIG +: W_DIG] = valor;
        end
        pronto_nxt = (estado == ULTIMA);
      end else begin
        erro_nxt = 1'b1;
      end
    end else if (press_v && (estado != '0)) begin
      for (int i = 0; i < int'(N_POS); i++) begin
        if (SW'(i) == (estado - SW'(1))) palpite_nxt[i*W_DIG +: W_DIG] = '0;
      end
    end
  end

endmodule

// File: tb/tb_fsm_registrador_palpite.sv
// Directed bench for fsm_registrador_palpite (N_POS=4, W_DIG=3, N_CORES=6).
module tb_fsm_registrador_palpite;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        botao = 1'b1;
  logic        voltar = 1'b0;
  logic        limpar = 1'b0;
  logic [2:0]  valor = 3'd2;
  logic [2:0]  estado;
  logic [11:0] palpite;
  logic        pronto, erro;

  int checks = 0;
  int errors = 0;

  fsm_registrador_palpite #(.N_POS(4), .W_DIG(3), .N_CORES(6)) dut (
    .CLK(CLK), .RST_N(RST_N), .botao(botao), .voltar(voltar), .limpar(limpar),
    .valor(valor), .estado(estado), .palpite(palpite), .pronto(pronto), .erro(erro)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        b, v, l;
    logic [2:0]  val;
    logic [2:0]  e_est;
    logic [11:0] e_pal;
    logic        e_pr, e_er;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic b, input logic v, input logic l, input logic [2:0] val,
                              input logic [2:0] e_est, input logic [11:0] e_pal,
                              input logic e_pr, input logic e_er);
    vec_t t;
    t.b = b; t.v = v; t.l = l; t.val = val;
    t.e_est = e_est; t.e_pal = e_pal; t.e_pr = e_pr; t.e_er = e_er;
    vq.push_back(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] e_est, input logic [11:0] e_pal,
                           input logic e_pr, input logic e_er);
    check({tag, " estado"},  32'(estado),  32'(e_est));
    check({tag, " palpite"}, 32'(palpite), 32'(e_pal));
    check({tag, " pronto"},  32'(pronto),  32'(e_pr));
    check({tag, " erro"},    32'(erro),    32'(e_er));
  endtask

  task automatic step(input logic rst_n, input logic b, input logic v, input logic l,
                      input logic [2:0] val);
    @(negedge CLK);
    RST_N = rst_n; botao = b; voltar = v; limpar = l; valor = val;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //  b  v  l  val   estado palpite  pr er
    add(0, 0, 0, 3'd2, 3'd0, 12'h000, 0, 0);
    add(1, 0, 0, 3'd2, 3'd1, 12'h002, 0, 0);
    add(1, 0, 0, 3'd2, 3'd1, 12'h002, 0, 0);
    add(0, 0, 0, 3'd2, 3'd1, 12'h002, 0, 0);
    add(0, 0, 1, 3'd0, 3'd0, 12'h000, 0, 0);
    add(1, 0, 0, 3'd1, 3'd1, 12'h001, 0, 0);
    add(0, 0, 0, 3'd1, 3'd1, 12'h001, 0, 0);
    add(1, 0, 0, 3'd2, 3'd2, 12'h011, 0, 0);
    add(0, 0, 0, 3'd2, 3'd2, 12'h011, 0, 0);
    add(1, 0, 0, 3'd7, 3'd2, 12'h011, 0, 1);
    add(0, 0, 0, 3'd7, 3'd2, 12'h011, 0, 0);
    add(1, 0, 0, 3'd3, 3'd3, 12'h0D1, 0, 0);
    add(0, 0, 0, 3'd3, 3'd3, 12'h0D1, 0, 0);
    add(1, 0, 0, 3'd4, 3'd4, 12'h8D1, 1, 0);
    add(0, 0, 0, 3'd4, 3'd4, 12'h8D1, 0, 0);
    add(0, 1, 0, 3'd0, 3'd3, 12'h0D1, 0, 0);
    add(0, 0, 0, 3'd0, 3'd3, 12'h0D1, 0, 0);
    add(0, 1, 0, 3'd0, 3'd2, 12'h011, 0, 0);
    add(0, 0, 0, 3'd0, 3'd2, 12'h011, 0, 0);
    add(1, 0, 0, 3'd3, 3'd3, 12'h0D1, 0, 0);
    add(0, 0, 0, 3'd3, 3'd3, 12'h0D1, 0, 0);
    add(1, 0, 0, 3'd5, 3'd4, 12'hAD1, 1, 0);
    add(0, 0, 0, 3'd5, 3'd4, 12'hAD1, 0, 0);
    add(1, 1, 0, 3'd5, 3'd4, 12'hAD1, 0, 0);
    add(0, 0, 0, 3'd5, 3'd4, 12'hAD1, 0, 0);
    add(1, 0, 0, 3'd7, 3'd0, 12'h000, 0, 0);
    add(0, 0, 0, 3'd7, 3'd0, 12'h000, 0, 0);
    add(0, 1, 0, 3'd0, 3'd0, 12'h000, 0, 0);
    add(0, 0, 0, 3'd0, 3'd0, 12'h000, 0, 0);
    add(1, 0, 0, 3'd6, 3'd0, 12'h000, 0, 1);
    add(0, 0, 0, 3'd6, 3'd0, 12'h000, 0, 0);
    add(1, 0, 0, 3'd0, 3'd1, 12'h000, 0, 0);
    add(0, 0, 0, 3'd0, 3'd1, 12'h000, 0, 0);
    add(1, 0, 0, 3'd5, 3'd2, 12'h028, 0, 0);
    add(0, 0, 0, 3'd5, 3'd2, 12'h028, 0, 0);
    add(1, 0, 1, 3'd3, 3'd0, 12'h000, 0, 0);
    add(0, 0, 0, 3'd3, 3'd0, 12'h000, 0, 0);

    // Reset with botao held, then leave reset still holding it: no press
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    check_all("reset", 3'd0, 12'h000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    check_all("held_after_reset", 3'd0, 12'h000, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      step(1'b1, vq[i].b, vq[i].v, vq[i].l, vq[i].val);
      check_all($sformatf("v%0d", i), vq[i].e_est, vq[i].e_pal, vq[i].e_pr, vq[i].e_er);
    end

    // Holding botao for 10 cycles advances only once
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
      check_all($sformatf("hold%0d", i), 3'd1, 12'h001, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    check_all("second_digit", 3'd2, 12'h011, 1'b0, 1'b0);

    // Reset mid-entry discards digits; held button needs a release afterwards
    step(1'b0, 1'b1, 1'b0, 1'b0, 3'd2);
    check_all("mid_reset", 3'd0, 12'h000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    check_all("mid_reset_held", 3'd0, 12'h000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2);
    check_all("press_after_reset", 3'd1, 12'h002, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
